video_dnn_class_histogram: RTL and testbench
============================================

Name: video_dnn_class_histogram

Overview:
- Downstream consumer of the DNN argmax stage.
- Passes the per-pixel class stream (tuser/tlast/tnumber/tcount/tdata) through with one register stage.
- Accumulates a per-frame histogram of winning class numbers, gated by a minimum-confidence threshold.
- On each frame boundary it commits the histogram to a result bank for host/OLED readout.

Parameters:
- NUM_CLASS, 10: number of classes; tnumber values >= NUM_CLASS are rejected.
- TNUMBER_WIDTH, 4: class index width.
- COUNT_WIDTH, 3: confidence (vote count) width.
- TUSER_WIDTH, 1: tuser width; bit 0 is start-of-frame.
- TDATA_WIDTH, 24: passthrough data width (must be >= 1).
- HIST_WIDTH, 20: per-class counter width; counters saturate.
- MIN_COUNT, 0: a pixel is counted only if tcount >= MIN_COUNT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cke  in  1  clock enable; all state holds while low
- s_axi4s_tuser  in  TUSER_WIDTH  bit 0 = SOF
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tnumber  in  TNUMBER_WIDTH  argmax class
- s_axi4s_tcount  in  COUNT_WIDTH  winning vote count
- s_axi4s_tdata  in  TDATA_WIDTH  passthrough data
- s_axi4s_tvalid  in  1
- s_axi4s_tready  out  1
- m_axi4s_tuser/tlast/tnumber/tcount/tdata  out  same widths as slave  registered copy of the slave beat
- m_axi4s_tvalid  out  1
- m_axi4s_tready  in  1
- hist_index  in  TNUMBER_WIDTH  result read address
- hist_count  out  HIST_WIDTH  result[hist_index], one-cycle latency
- hist_pixels  out  HIST_WIDTH  total accepted pixels in the committed frame (saturating)
- hist_reject  out  HIST_WIDTH  pixels dropped by threshold or tnumber range
- hist_valid  out  1  one-cycle pulse on commit

Behaviour:
- Clock and reset: one clock domain; reset is synchronous, active-high on `reset`.
- Reset values: m_axi4s_tvalid=0; hist_valid=0; all accumulators, results, hist_count, hist_pixels and hist_reject = 0; FSM in IDLE.
- Handshake: s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready.
  - A beat is accepted when s_tvalid && s_tready && cke.
  - The output register loads the beat on acceptance.
  - m_tvalid clears on m_tready with no new beat.
  - Latency is 1 cycle. Full throughput with a continuously ready sink.
- Qualified pixel: tnumber < NUM_CLASS && tcount >= MIN_COUNT. Any other accepted pixel increments the reject accumulator.
- FSM IDLE:
  - Accepted beats with SOF=0 are ignored for statistics but still passed through.
  - A beat with SOF=1 clears all accumulators, counts that pixel, and moves to COUNT.
- FSM COUNT:
  - Accepted beats with SOF=0 update acc[tnumber], the pixel accumulator and the reject accumulator.
  - A beat with SOF=1 triggers a commit:
    - result[], pixels and reject are loaded from the accumulators, excluding the current pixel.
    - hist_valid pulses next cycle.
    - Accumulators restart holding only the current pixel.
- Saturation: every counter stops at 2^HIST_WIDTH-1; no wrap.
- Readout: hist_count is registered from result[hist_index]. An index >= NUM_CLASS returns 0.
  - If a read and a commit occur in the same cycle, the read returns the pre-commit value.
- Backpressure: while cke=0 or the beat is not accepted, nothing updates and hist_valid stays 0.
- Reset mid-frame: discards the partial histogram and returns to IDLE. The next SOF starts a fresh frame.

Optional Feature:
- VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN defined:
  - Adds outputs hist_max_number (TNUMBER_WIDTH) and hist_max_valid (1).
  - After each commit a scan FSM walks result[0..NUM_CLASS-1], one entry per cke cycle.
  - Ties keep the lower index.
  - hist_max_valid pulses NUM_CLASS+1 cycles after hist_valid.
  - A new commit during a scan restarts the scan.
  - Reset values: hist_max_number=0, hist_max_valid=0.
- Undefined: neither port exists and there is no scan logic.

Decomposition:
- Shared package video_dnn_pkg holds:
  - the SOF bit position constant;
  - the FSM state encoding (IDLE=0, COUNT=1);
  - the scan states for the optional feature.
- One natural sub-module, video_dnn_sat_counter:
  - parameterised width;
  - clear, load-one and increment controls;
  - saturating;
  - used for the per-class, pixel and reject accumulators.

Test Plan:
- Reset then idle: all outputs 0, s_tready=1, hist_valid never pulses.
- Throughput and latency:
  - Stimulus: 2 frames of 4x2 pixels, tnumber pattern 0,1,1,2,..., tcount=7, sink always ready.
  - Response: m stream identical with 1-cycle latency; at frame-2 SOF, hist_valid=1 and result = class0:1, class1:2, class2:...; hist_pixels=8.
- Threshold and range rejection:
  - Stimulus: MIN_COUNT=4; pixels with tcount=3 and tnumber=12.
  - Response: hist_reject=2; neither pixel appears in hist_count.
- Backpressure:
  - Stimulus: random m_tready and cke toggling across one frame.
  - Response: no lost or duplicated beats; histogram equals the reference count.
- Saturation:
  - Stimulus: HIST_WIDTH=4, 20 pixels of class 3 in one frame.
  - Response: hist_count[3]=15, hist_pixels=15.
- Reset and max scan:
  - Stimulus: reset asserted mid-frame, then a fresh frame.
  - Response: only post-reset pixels are counted.
  - With VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN: hist_max_number = majority class, with hist_max_valid at hist_valid+11 cycles (NUM_CLASS=10).

Source files
------------

// File: rtl/video_dnn_pkg.sv
// Shared definitions for the DNN class-histogram slice: SOF bit position,
// frame FSM encoding and the optional max-scan FSM encoding.
package video_dnn_pkg;

   localparam int SOF_BIT = 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } hist_state_e;

   typedef enum logic [1:0] {
      SCAN_IDLE = 2'd0,
      SCAN_RUN  = 2'd1,
      SCAN_DONE = 2'd2
   } scan_state_e;

endpackage

// File: rtl/video_dnn_sat_counter.sv
// Saturating up-counter with clear, load-one and increment controls.
// load_one takes priority so a frame restart can seed the counter with the current pixel.
module video_dnn_sat_counter #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             load_one_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_one_i) begin
         count_d = WIDTH'(1);
      end else if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/video_dnn_class_histogram.sv
// Per-frame histogram of argmax class numbers with a one-stage AXI4-Stream passthrough.
// Define VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN to add the post-commit majority-class scan.
module video_dnn_class_histogram
   import video_dnn_pkg::*;
#(
   parameter int NUM_CLASS     = 10,
   parameter int TNUMBER_WIDTH = 4,
   parameter int COUNT_WIDTH   = 3,
   parameter int TUSER_WIDTH   = 1,
   parameter int TDATA_WIDTH   = 24,
   parameter int HIST_WIDTH    = 20,
   parameter int MIN_COUNT     = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cke,
   input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
   input  logic                     s_axi4s_tlast,
   input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
   input  logic [COUNT_WIDTH-1:0]   s_axi4s_tcount,
   input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
   input  logic                     s_axi4s_tvalid,
   output logic                     s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
   output logic                     m_axi4s_tlast,
   output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
   output logic [COUNT_WIDTH-1:0]   m_axi4s_tcount,
   output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
   output logic                     m_axi4s_tvalid,
   input  logic                     m_axi4s_tready,
   input  logic [TNUMBER_WIDTH-1:0] hist_index,
   output logic [HIST_WIDTH-1:0]    hist_count,
   output logic [HIST_WIDTH-1:0]    hist_pixels,
   output logic [HIST_WIDTH-1:0]    hist_reject,
`ifdef VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN
   output logic                     hist_valid,
   output logic [TNUMBER_WIDTH-1:0] hist_max_number,
   output logic                     hist_max_valid
`else
   output logic                     hist_valid
`endif
);

   logic [TUSER_WIDTH-1:0]   m_tuser_q;
   logic                     m_tlast_q;
   logic [TNUMBER_WIDTH-1:0] m_tnumber_q;
   logic [COUNT_WIDTH-1:0]   m_tcount_q;
   logic [TDATA_WIDTH-1:0]   m_tdata_q;
   logic                     m_tvalid_q;

   hist_state_e              state_q;
   logic [HIST_WIDTH-1:0]    result_q [NUM_CLASS];
   logic [HIST_WIDTH-1:0]    acc_s    [NUM_CLASS];
   logic [HIST_WIDTH-1:0]    pix_acc_s;
   logic [HIST_WIDTH-1:0]    rej_acc_s;
   logic [HIST_WIDTH-1:0]    pixels_q;
   logic [HIST_WIDTH-1:0]    reject_q;
   logic [HIST_WIDTH-1:0]    hist_count_q;
   logic                     hist_valid_q;

   logic accept_s;
   logic sof_s;
   logic qual_s;
   logic restart_s;
   logic count_s;
   logic commit_s;

   assign s_axi4s_tready = !m_tvalid_q || m_axi4s_tready;
   assign accept_s       = s_axi4s_tvalid && s_axi4s_tready && cke;
   assign sof_s          = s_axi4s_tuser[SOF_BIT];
   assign qual_s         = (int'(s_axi4s_tnumber) < NUM_CLASS) && (int'(s_axi4s_tcount) >= MIN_COUNT);
   // Any SOF restarts the accumulators; only an SOF inside a frame commits them.
   assign restart_s      = accept_s && sof_s;
   assign count_s        = accept_s && !sof_s && (state_q == ST_COUNT);
   assign commit_s       = restart_s && (state_q == ST_COUNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         m_tvalid_q  <= 1'b0;
         m_tuser_q   <= '0;
         m_tlast_q   <= 1'b0;
         m_tnumber_q <= '0;
         m_tcount_q  <= '0;
         m_tdata_q   <= '0;
      end else if (cke) begin
         if (accept_s) begin
            m_tvalid_q  <= 1'b1;
            m_tuser_q   <= s_axi4s_tuser;
            m_tlast_q   <= s_axi4s_tlast;
            m_tnumber_q <= s_axi4s_tnumber;
            m_tcount_q  <= s_axi4s_tcount;
            m_tdata_q   <= s_axi4s_tdata;
         end else if (m_axi4s_tready) begin
            m_tvalid_q <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NUM_CLASS; k++) begin : g_acc
      logic hit_s;
      assign hit_s = qual_s && (int'(s_axi4s_tnumber) == k);
      video_dnn_sat_counter #(.WIDTH(HIST_WIDTH)) u_acc (
         .clk        (clk),
         .reset      (reset),
         .clr_i      (restart_s && !hit_s),
         .load_one_i (restart_s && hit_s),
         .inc_i      (count_s && hit_s),
         .count_o    (acc_s[k])
      );
   end

   // Pixel total counts only qualified pixels; everything else lands in reject.
   video_dnn_sat_counter #(.WIDTH(HIST_WIDTH)) u_pix (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (restart_s && !qual_s),
      .load_one_i (restart_s && qual_s),
      .inc_i      (count_s && qual_s),
      .count_o    (pix_acc_s)
   );

   video_dnn_sat_counter #(.WIDTH(HIST_WIDTH)) u_rej (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (restart_s && qual_s),
      .load_one_i (restart_s && !qual_s),
      .inc_i      (count_s && !qual_s),
      .count_o    (rej_acc_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pixels_q     <= '0;
         reject_q     <= '0;
         hist_count_q <= '0;
         hist_valid_q <= 1'b0;
         for (int k = 0; k < NUM_CLASS; k++) begin
            result_q[k] <= '0;
         end
      end else begin
         hist_valid_q <= commit_s;
         if (cke) begin
            hist_count_q <= (int'(hist_index) < NUM_CLASS) ? result_q[hist_index] : '0;
            if (restart_s) begin
               state_q <= ST_COUNT;
            end
            if (commit_s) begin
               pixels_q <= pix_acc_s;
               reject_q <= rej_acc_s;
               for (int k = 0; k < NUM_CLASS; k++) begin
                  result_q[k] <= acc_s[k];
               end
            end
         end
      end
   end

   assign m_axi4s_tuser   = m_tuser_q;
   assign m_axi4s_tlast   = m_tlast_q;
   assign m_axi4s_tnumber = m_tnumber_q;
   assign m_axi4s_tcount  = m_tcount_q;
   assign m_axi4s_tdata   = m_tdata_q;
   assign m_axi4s_tvalid  = m_tvalid_q;
   assign hist_count      = hist_count_q;
   assign hist_pixels     = pixels_q;
   assign hist_reject     = reject_q;
   assign hist_valid      = hist_valid_q;

`ifdef VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN
   scan_state_e              scan_q;
   logic [TNUMBER_WIDTH-1:0] scan_idx_q;
   logic [TNUMBER_WIDTH-1:0] best_num_q;
   logic [HIST_WIDTH-1:0]    best_val_q;
   logic [TNUMBER_WIDTH-1:0] max_number_q;
   logic                     max_valid_q;

   // Strict greater-than keeps the lower index on ties.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_q       <= SCAN_IDLE;
         scan_idx_q   <= '0;
         best_num_q   <= '0;
         best_val_q   <= '0;
         max_number_q <= '0;
         max_valid_q  <= 1'b0;
      end else begin
         max_valid_q <= 1'b0;
         if (commit_s) begin
            scan_q     <= SCAN_RUN;
            scan_idx_q <= '0;
            best_num_q <= '0;
            best_val_q <= '0;
         end else if (cke) begin
            case (scan_q)
               SCAN_RUN: begin
                  if (result_q[scan_idx_q] > best_val_q) begin
                     best_val_q <= result_q[scan_idx_q];
                     best_num_q <= scan_idx_q;
                  end
                  if (int'(scan_idx_q) == NUM_CLASS - 1) begin
                     scan_q <= SCAN_DONE;
                  end else begin
                     scan_idx_q <= scan_idx_q + TNUMBER_WIDTH'(1);
                  end
               end
               SCAN_DONE: begin
                  max_number_q <= best_num_q;
                  max_valid_q  <= 1'b1;
                  scan_q       <= SCAN_IDLE;
               end
               SCAN_IDLE: scan_q <= SCAN_IDLE;
               default:   scan_q <= SCAN_IDLE;
            endcase
         end
      end
   end

   assign hist_max_number = max_number_q;
   assign hist_max_valid  = max_valid_q;
`endif

endmodule

// File: tb/tb_video_dnn_class_histogram.sv
// Directed bench: passthrough scoreboard, histogram reference model, threshold,
// backpressure, saturation (HIST_WIDTH=4) and mid-frame reset.
module tb_video_dnn_class_histogram;

   localparam int NC   = 10;
   localparam int TNW  = 4;
   localparam int CW   = 3;
   localparam int TUW  = 1;
   localparam int TDW  = 24;
   localparam int HW   = 4;
   localparam int MINC = 4;
   localparam int HMAX = 15;

   logic            clk = 1'b0;
   logic            reset;
   logic            cke;
   logic [TUW-1:0]  s_axi4s_tuser;
   logic            s_axi4s_tlast;
   logic [TNW-1:0]  s_axi4s_tnumber;
   logic [CW-1:0]   s_axi4s_tcount;
   logic [TDW-1:0]  s_axi4s_tdata;
   logic            s_axi4s_tvalid;
   logic            s_axi4s_tready;
   logic [TUW-1:0]  m_axi4s_tuser;
   logic            m_axi4s_tlast;
   logic [TNW-1:0]  m_axi4s_tnumber;
   logic [CW-1:0]   m_axi4s_tcount;
   logic [TDW-1:0]  m_axi4s_tdata;
   logic            m_axi4s_tvalid;
   logic            m_axi4s_tready;
   logic [TNW-1:0]  hist_index;
   logic [HW-1:0]   hist_count;
   logic [HW-1:0]   hist_pixels;
   logic [HW-1:0]   hist_reject;
   logic            hist_valid;
`ifdef VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN
   logic [TNW-1:0]  hist_max_number;
   logic            hist_max_valid;
`endif

   always #5 clk = ~clk;

   video_dnn_class_histogram #(
      .NUM_CLASS(NC), .TNUMBER_WIDTH(TNW), .COUNT_WIDTH(CW), .TUSER_WIDTH(TUW),
      .TDATA_WIDTH(TDW), .HIST_WIDTH(HW), .MIN_COUNT(MINC)
   ) dut (
      .clk(clk), .reset(reset), .cke(cke),
      .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
      .s_axi4s_tnumber(s_axi4s_tnumber), .s_axi4s_tcount(s_axi4s_tcount),
      .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
      .s_axi4s_tready(s_axi4s_tready),
      .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
      .m_axi4s_tnumber(m_axi4s_tnumber), .m_axi4s_tcount(m_axi4s_tcount),
      .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
      .m_axi4s_tready(m_axi4s_tready),
      .hist_index(hist_index), .hist_count(hist_count), .hist_pixels(hist_pixels),
      .hist_reject(hist_reject),
`ifdef VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN
      .hist_valid(hist_valid), .hist_max_number(hist_max_number),
      .hist_max_valid(hist_max_valid)
`else
      .hist_valid(hist_valid)
`endif
   );

   typedef struct packed {
      logic [32:0] beat;
      logic [31:0] cyc;
   } sb_t;

   sb_t         sbq[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] cyc = 32'd0;
   bit          rand_mode = 1'b0;
   bit          lat_chk = 1'b0;
   int          mdl_cur[NC];
   int          mdl_com[NC];
   int          cur_pix, cur_rej, com_pix, com_rej;
   bit          in_frame;
   bit          hv_exp;
   int          max_seen = 0;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v < HMAX) ? v + 1 : v;
   endfunction

`ifdef VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN
   function automatic int argmax();
      int b = 0;
      for (int k = 1; k < NC; k++) if (mdl_com[k] > mdl_com[b]) b = k;
      return b;
   endfunction
`endif

   task automatic send_beat(input bit sof, input bit last, input int num, input int cnt);
      bit ok = 1'b0;
      s_axi4s_tuser   = TUW'(sof);
      s_axi4s_tlast   = last;
      s_axi4s_tnumber = TNW'(num);
      s_axi4s_tcount  = CW'(cnt);
      s_axi4s_tdata   = TDW'($urandom);
      s_axi4s_tvalid  = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = s_axi4s_tready && cke;
         @(posedge clk);
         #1;
      end
      check("send_accept", 64'(ok), 64'd1);
   endtask

   task automatic stop();
      s_axi4s_tvalid = 1'b0;
   endtask

   task automatic read_hist(input int idx, input int exp);
      hist_index = TNW'(idx);
      @(posedge clk);
      #1;
      check($sformatf("hist_count[%0d]", idx), 64'(hist_count), 64'(exp));
   endtask

   initial begin
      reset = 1'b1; cke = 1'b1; m_axi4s_tready = 1'b1;
      s_axi4s_tvalid = 1'b0; s_axi4s_tuser = '0; s_axi4s_tlast = 1'b0;
      s_axi4s_tnumber = '0; s_axi4s_tcount = '0; s_axi4s_tdata = '0;
      hist_index = '0;
      fork
         forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
               cke = ($urandom_range(0, 3) != 0);
               m_axi4s_tready = ($urandom_range(0, 1) == 1);
            end else begin
               cke = 1'b1;
               m_axi4s_tready = 1'b1;
            end
         end
         forever begin : monitor
            sb_t e;
            bit  q;
            int  n;
`ifdef VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN
            logic [31:0] hv_cyc;
            bit          stall;
`endif
            @(negedge clk);
            if (reset) begin
               sbq.delete();
               in_frame = 1'b0; hv_exp = 1'b0;
               cur_pix = 0; cur_rej = 0; com_pix = 0; com_rej = 0;
               for (int k = 0; k < NC; k++) begin mdl_cur[k] = 0; mdl_com[k] = 0; end
            end else begin
               check("hist_valid", 64'(hist_valid), 64'(hv_exp));
               if (hist_valid) begin
                  check("hist_pixels", 64'(hist_pixels), 64'(com_pix));
                  check("hist_reject", 64'(hist_reject), 64'(com_rej));
               end
               hv_exp = 1'b0;
`ifdef VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN
               if (hist_valid) begin hv_cyc = cyc; stall = 1'b0; end
               if (!cke) stall = 1'b1;
               if (hist_max_valid) begin
                  max_seen++;
                  check("hist_max_number", 64'(hist_max_number), 64'(argmax()));
                  if (!stall) check("hist_max_latency", 64'(cyc - hv_cyc), 64'd11);
               end
`endif
               if (m_axi4s_tvalid && m_axi4s_tready && cke) begin
                  if (sbq.size() == 0) begin
                     check("m_beat_unexpected", 64'(sbq.size()), 64'd1);
                  end else begin
                     e = sbq.pop_front();
                     check("m_beat", 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber,
                                          m_axi4s_tcount, m_axi4s_tdata}), 64'(e.beat));
                     if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd1);
                  end
               end
               if (s_axi4s_tvalid && s_axi4s_tready && cke) begin
                  sbq.push_back('{beat: {s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tnumber,
                                         s_axi4s_tcount, s_axi4s_tdata}, cyc: cyc});
                  n = int'(s_axi4s_tnumber);
                  q = (n < NC) && (int'(s_axi4s_tcount) >= MINC);
                  if (s_axi4s_tuser[0]) begin
                     if (in_frame) begin
                        for (int k = 0; k < NC; k++) mdl_com[k] = mdl_cur[k];
                        com_pix = cur_pix; com_rej = cur_rej; hv_exp = 1'b1;
                     end
                     for (int k = 0; k < NC; k++) mdl_cur[k] = 0;
                     cur_pix = 0; cur_rej = 0; in_frame = 1'b1;
                  end
                  if (in_frame) begin
                     if (q) begin mdl_cur[n] = sat(mdl_cur[n]); cur_pix = sat(cur_pix); end
                     else cur_rej = sat(cur_rej);
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", 64'(m_axi4s_tvalid), 64'd0);
      check("rst_s_tready", 64'(s_axi4s_tready), 64'd1);
      check("rst_hist_valid", 64'(hist_valid), 64'd0);
      check("rst_hist_count", 64'(hist_count), 64'd0);
      check("rst_hist_pixels", 64'(hist_pixels), 64'd0);
      check("rst_hist_reject", 64'(hist_reject), 64'd0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("idle_m_tvalid", 64'(m_axi4s_tvalid), 64'd0);

      // Throughput: stray beats in IDLE, then two 4x2 frames back to back
      lat_chk = 1'b1;
      send_beat(1'b0, 1'b0, 2, 7);
      send_beat(1'b0, 1'b1, 2, 7);
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 8; i++) begin
            send_beat(i == 0, (i % 4) == 3, (i == 0) ? 0 : (i < 3) ? 1 : (i < 6) ? 2 : 3, 7);
            if (f == 1 && i == 0) begin
               check("frameA_hist_valid", 64'(hist_valid), 64'd1);
               check("frameA_pixels", 64'(hist_pixels), 64'd8);
            end
         end
      end
      send_beat(1'b1, 1'b0, 4, 7);
      stop();
      check("frameB_pixels", 64'(hist_pixels), 64'd8);
      read_hist(0, 1); read_hist(1, 2); read_hist(2, 3); read_hist(3, 2);
      read_hist(4, 0); read_hist(12, 0);

      // Threshold and range rejection
      send_beat(1'b0, 1'b0, 5, 3);
      send_beat(1'b0, 1'b0, 12, 7);
      send_beat(1'b0, 1'b0, 5, 4);
      send_beat(1'b0, 1'b1, 9, 7);
      send_beat(1'b1, 1'b0, 0, 7);
      stop();
      check("thr_reject", 64'(hist_reject), 64'd2);
      check("thr_pixels", 64'(hist_pixels), 64'd3);
      read_hist(5, 1); read_hist(12, 0); read_hist(9, 1); read_hist(4, 1);

      // Backpressure with random sink ready and cke
      lat_chk = 1'b0;
      rand_mode = 1'b1;
      for (int i = 1; i < 12; i++) begin
         send_beat(1'b0, (i % 4) == 3, $urandom_range(0, 11), $urandom_range(0, 7));
      end
      send_beat(1'b1, 1'b0, 3, 7);
      stop();
      rand_mode = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("bp_drained", 64'(sbq.size()), 64'd0);
      for (int k = 0; k < NC; k++) read_hist(k, mdl_com[k]);

      // Saturation: 20 class-3 pixels in one frame
      for (int i = 1; i < 20; i++) send_beat(1'b0, 1'b0, 3, 7);
      send_beat(1'b1, 1'b0, 7, 7);
      stop();
      check("sat_pixels", 64'(hist_pixels), 64'd15);
      read_hist(3, 15);

      // Reset mid-frame, then a fresh frame
      send_beat(1'b0, 1'b0, 1, 7);
      send_beat(1'b0, 1'b0, 1, 7);
      stop();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_m_tvalid", 64'(m_axi4s_tvalid), 64'd0);
      check("mid_rst_pixels", 64'(hist_pixels), 64'd0);
      read_hist(3, 0);
      send_beat(1'b0, 1'b0, 2, 7);
      send_beat(1'b1, 1'b0, 7, 7);
      send_beat(1'b0, 1'b0, 7, 7);
      send_beat(1'b0, 1'b0, 7, 7);
      send_beat(1'b0, 1'b0, 2, 7);
      send_beat(1'b0, 1'b0, 7, 7);
      send_beat(1'b0, 1'b1, 1, 7);
      send_beat(1'b1, 1'b0, 0, 7);
      stop();
      check("fresh_pixels", 64'(hist_pixels), 64'd6);
      read_hist(7, 4); read_hist(1, 1); read_hist(2, 1); read_hist(3, 0);
      repeat (20) @(posedge clk);
      #1;
`ifdef VIDEO_DNN_CLASS_HISTOGRAM_MAX_EN
      check("max_seen", 64'(max_seen > 0), 64'd1);
      check("final_max_number", 64'(hist_max_number), 64'd7);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
